// File: rtl/m_mem_ctrl_pkg.sv
// Shared encodings for the M-stage memory controller: FSM states,
// store/load size selects, bus size codes and address-error ExcCodes.
package m_mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DONE   = 3'd3,
        ST_CANCEL = 3'd4
    } memState_t;

    // MemInSelM: store size
    localparam logic [1:0] MIS_WORD = 2'd0;
    localparam logic [1:0] MIS_HALF = 2'd1;
    localparam logic [1:0] MIS_BYTE = 2'd2;

    // MemOutSelM: load type
    localparam logic [2:0] MOS_LW  = 3'd0;
    localparam logic [2:0] MOS_LBU = 3'd1;
    localparam logic [2:0] MOS_LB  = 3'd2;
    localparam logic [2:0] MOS_LHU = 3'd3;
    localparam logic [2:0] MOS_LH  = 3'd4;

    // data_size on the bus
    localparam logic [1:0] DSIZE_BYTE = 2'd0;
    localparam logic [1:0] DSIZE_HALF = 2'd1;
    localparam logic [1:0] DSIZE_WORD = 2'd2;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    // Bus access size of the instruction; stores use MemInSel, loads MemOutSel.
    function automatic logic [1:0] accessSize(input logic isStore,
                                              input logic [1:0] inSel,
                                              input logic [2:0] outSel);
        logic [1:0] sz;
        sz = DSIZE_WORD;
        if (isStore) begin
            case (inSel)
                MIS_BYTE: sz = DSIZE_BYTE;
                MIS_HALF: sz = DSIZE_HALF;
                MIS_WORD: sz = DSIZE_WORD;
                default:  sz = DSIZE_WORD;
            endcase
        end else begin
            case (outSel)
                MOS_LBU, MOS_LB: sz = DSIZE_BYTE;
                MOS_LHU, MOS_LH: sz = DSIZE_HALF;
                default:         sz = DSIZE_WORD;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/m_load_ext.sv
// Selects the addressed byte/half of a load response and zero- or
// sign-extends it according to the load type.
module m_load_ext
    import m_mem_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addrLo,
    input  logic [2:0]  outSel,
    output logic [31:0] result
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Lane select followed by extension
    always_comb begin
        case (addrLo)
            2'd0:    byteSel = rdata[7:0];
            2'd1:    byteSel = rdata[15:8];
            2'd2:    byteSel = rdata[23:16];
            default: byteSel = rdata[31:24];
        endcase
        halfSel = addrLo[1] ? rdata[31:16] : rdata[15:0];
        case (outSel)
            MOS_LW:  result = rdata;
            MOS_LBU: result = {24'h0, byteSel};
            MOS_LB:  result = {{24{byteSel[7]}}, byteSel};
            MOS_LHU: result = {16'h0, halfSel};
            MOS_LH:  result = {{16{halfSel[15]}}, halfSel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/m_mem_ctrl.sv
// M-stage memory-access controller: runs the data-bus req/addr_ok/data_ok
// handshake for loads and stores, builds strobes and lane data, extends load
// results and flags address-alignment exceptions.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | no bus activity; non-memory / excepting ops pass straight on
// ST_REQ    | data_req high with request fields frozen, waiting for addr_ok
// ST_WAIT   | address accepted, waiting for data_ok
// ST_DONE   | result ready, M_to_W_valid high until W accepts
// ST_CANCEL | flushed with a transaction in flight; drain data_ok and drop it
module m_mem_ctrl
    import m_mem_ctrl_pkg::*;
#(
    parameter int         ADDR_W   = 32,
    parameter logic [4:0] EXC_ADEL = m_mem_ctrl_pkg::EXC_ADEL,
    parameter logic [4:0] EXC_ADES = m_mem_ctrl_pkg::EXC_ADES
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              respon,
    input  logic              M_valid,
    input  logic              W_allowin,
    input  logic              MemWriteM,
    input  logic              MemOrALUM,
    input  logic [1:0]        MemInSelM,
    input  logic [2:0]        MemOutSelM,
    input  logic [31:0]       ALUoutM,
    input  logic [31:0]       rd2M,
    input  logic              EXLM,
    input  logic [4:0]        ExcCodeM,
    output logic              M_allowin,
    output logic              M_to_W_valid,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [3:0]        data_wstrb,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata,
    output logic [31:0]       mem_rdataM,
    output logic              exc_validM,
    output logic [4:0]        exc_codeM
);

    memState_t   state;
    logic [2:0]  loadSel;
    logic        isMem;
    logic        misalign;
    logic        memOp;
    logic [1:0]  addrLo;
    logic [1:0]  accSize;
    logic [3:0]  wstrbNext;
    logic [31:0] wdataNext;
    logic [31:0] loadExt;

    assign isMem    = MemWriteM || MemOrALUM;
    assign addrLo   = ALUoutM[1:0];
    assign accSize  = accessSize(MemWriteM, MemInSelM, MemOutSelM);
    assign misalign = isMem && ((accSize == DSIZE_WORD && addrLo != 2'b00) ||
                                (accSize == DSIZE_HALF && addrLo[0]));

    assign exc_validM = M_valid && (EXLM || misalign);
    assign exc_codeM  = EXLM ? ExcCodeM : (MemWriteM ? EXC_ADES : EXC_ADEL);
    assign memOp      = M_valid && isMem && !exc_validM;

    // Store strobes and lane-replicated write data
    always_comb begin
        wstrbNext = 4'h0;
        wdataNext = rd2M;
        if (MemWriteM) begin
            case (MemInSelM)
                MIS_BYTE: begin
                    wstrbNext = 4'b0001 << addrLo;
                    wdataNext = {4{rd2M[7:0]}};
                end
                MIS_HALF: begin
                    wstrbNext = addrLo[1] ? 4'b1100 : 4'b0011;
                    wdataNext = {2{rd2M[15:0]}};
                end
                default: begin
                    wstrbNext = 4'hF;
                    wdataNext = rd2M;
                end
            endcase
        end
    end

    // Extension uses the frozen request address and load type
    m_load_ext u_load_ext (
        .rdata  (data_rdata),
        .addrLo (data_addr[1:0]),
        .outSel (loadSel),
        .result (loadExt)
    );

    // Handshake toward W; a flush cycle never presents a result
    always_comb begin
        case (state)
            ST_IDLE: M_to_W_valid = M_valid && !memOp && !respon;
            ST_DONE: M_to_W_valid = !respon;
            default: M_to_W_valid = 1'b0;
        endcase
    end

    assign M_allowin = (state == ST_IDLE || state == ST_DONE) &&
                       (!M_valid || (M_to_W_valid && W_allowin));

    // Bus transaction FSM with registered request fields and load result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= DSIZE_WORD;
            data_addr  <= '0;
            data_wstrb <= 4'h0;
            data_wdata <= 32'h0;
            loadSel    <= MOS_LW;
            mem_rdataM <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (memOp && !respon) begin
                        state      <= ST_REQ;
                        data_req   <= 1'b1;
                        data_wr    <= MemWriteM;
                        data_size  <= accSize;
                        data_addr  <= ALUoutM[ADDR_W-1:0];
                        data_wstrb <= wstrbNext;
                        data_wdata <= wdataNext;
                        loadSel    <= MemOutSelM;
                    end
                end
                ST_REQ: begin
                    if (data_addr_ok) begin
                        data_req <= 1'b0;
                        if (data_data_ok) begin
                            if (!respon && !data_wr) begin
                                mem_rdataM <= loadExt;
                            end
                            state <= respon ? ST_IDLE : ST_DONE;
                        end else begin
                            state <= respon ? ST_CANCEL : ST_WAIT;
                        end
                    end else if (respon) begin
                        data_req <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // A response coinciding with the flush already closes the transaction
                    if (respon) begin
                        state <= data_data_ok ? ST_IDLE : ST_CANCEL;
                    end else if (data_data_ok) begin
                        if (!data_wr) begin
                            mem_rdataM <= loadExt;
                        end
                        state <= ST_DONE;
                    end
                end
                ST_CANCEL: begin
                    if (data_data_ok) begin
                        state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    if (respon || W_allowin) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m_mem_ctrl.sv
// Bench for m_mem_ctrl: directed scenarios followed by randomized ops,
// checked against a byte-arithmetic model of loads, stores and alignment.
module tb_m_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        respon;
    logic        M_valid;
    logic        W_allowin;
    logic        MemWriteM;
    logic        MemOrALUM;
    logic [1:0]  MemInSelM;
    logic [2:0]  MemOutSelM;
    logic [31:0] ALUoutM;
    logic [31:0] rd2M;
    logic        EXLM;
    logic [4:0]  ExcCodeM;
    logic        M_allowin;
    logic        M_to_W_valid;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] mem_rdataM;
    logic        exc_validM;
    logic [4:0]  exc_codeM;

    int          total = 0;
    int          bad = 0;
    logic [31:0] expRdata;
    int          kind;
    int          sel;
    logic [31:0] addr;

    m_mem_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .respon       (respon),
        .M_valid      (M_valid),
        .W_allowin    (W_allowin),
        .MemWriteM    (MemWriteM),
        .MemOrALUM    (MemOrALUM),
        .MemInSelM    (MemInSelM),
        .MemOutSelM   (MemOutSelM),
        .ALUoutM      (ALUoutM),
        .rd2M         (rd2M),
        .EXLM         (EXLM),
        .ExcCodeM     (ExcCodeM),
        .M_allowin    (M_allowin),
        .M_to_W_valid (M_to_W_valid),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_rdataM   (mem_rdataM),
        .exc_validM   (exc_validM),
        .exc_codeM    (exc_codeM)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 ALU op, 1 load, 2 store
    function automatic int opBytes(input int k, input int s);
        if (k == 2) return (s == 0) ? 4 : (s == 1) ? 2 : 1;
        if (k == 1) return (s == 0) ? 4 : (s <= 2) ? 1 : 2;
        return 4;
    endfunction

    function automatic logic [31:0] loadModel(input int s, input logic [1:0] a, input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> (8 * a);
        case (s)
            1:       return sh & 32'hFF;
            2:       return 32'($signed(sh[7:0]));
            3:       return sh & 32'hFFFF;
            4:       return 32'($signed(sh[15:0]));
            default: return rd;
        endcase
    endfunction

    task automatic runOp(input int k, input int s, input logic [31:0] ad, input logic [31:0] wd,
                         input logic [31:0] rd, input int aDly, input int dDly, input int wDly,
                         input logic exl, input logic [4:0] code);
        int          nb;
        int          a;
        logic        expExc;
        logic [4:0]  expCode;
        logic [3:0]  expStrb;
        logic [31:0] expWdata;
        logic [1:0]  expSize;
        nb       = opBytes(k, s);
        a        = int'(ad[1:0]);
        expExc   = exl || (k != 0 && (a % nb) != 0);
        expCode  = exl ? code : ((k == 2) ? 5'd5 : 5'd4);
        expSize  = (nb == 1) ? 2'd0 : (nb == 2) ? 2'd1 : 2'd2;
        expStrb  = (k != 2) ? 4'h0 : (nb == 4) ? 4'hF : 4'(((1 << nb) - 1) << a);
        expWdata = (nb == 1) ? (wd & 32'hFF) * 32'h01010101 :
                   (nb == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;

        M_valid    = 1'b1;
        MemWriteM  = (k == 2);
        MemOrALUM  = (k == 1);
        MemInSelM  = (k == 2) ? 2'(s) : 2'($urandom_range(0, 2));
        MemOutSelM = (k == 1) ? 3'(s) : 3'($urandom_range(0, 4));
        ALUoutM    = ad;
        rd2M       = wd;
        EXLM       = exl;
        ExcCodeM   = code;
        W_allowin  = (wDly == 0);
        @(negedge clk);
        check("exc_valid", 32'(exc_validM), 32'(expExc));
        if (expExc) check("exc_code", 32'(exc_codeM), 32'(expCode));

        if (k == 0 || expExc) begin
            for (int i = 0; i <= wDly; i++) begin
                if (i > 0) begin
                    W_allowin = (i == wDly);
                    @(negedge clk);
                end
                check("pass_valid", 32'(M_to_W_valid), 32'd1);
                check("pass_allowin", 32'(M_allowin), 32'(i == wDly));
                check("pass_noreq", 32'(data_req), 32'd0);
                tick();
            end
        end else begin
            check("idle_valid", 32'(M_to_W_valid), 32'd0);
            check("idle_allowin", 32'(M_allowin), 32'd0);
            check("idle_noreq", 32'(data_req), 32'd0);
            tick();
            for (int i = 0; i <= aDly; i++) begin
                data_addr_ok = (i == aDly);
                data_data_ok = (i == aDly) && (dDly == 0);
                data_rdata   = data_data_ok ? rd : $urandom;
                @(negedge clk);
                check("req", 32'(data_req), 32'd1);
                check("req_allowin", 32'(M_allowin), 32'd0);
                check("req_addr", data_addr, ad);
                check("req_size", 32'(data_size), 32'(expSize));
                check("req_wr", 32'(data_wr), 32'(k == 2));
                check("req_wstrb", 32'(data_wstrb), 32'(expStrb));
                if (k == 2) check("req_wdata", data_wdata, expWdata);
                tick();
            end
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
            for (int i = 1; i <= dDly; i++) begin
                data_data_ok = (i == dDly);
                data_rdata   = data_data_ok ? rd : $urandom;
                @(negedge clk);
                check("wait_noreq", 32'(data_req), 32'd0);
                check("wait_allowin", 32'(M_allowin), 32'd0);
                check("wait_valid", 32'(M_to_W_valid), 32'd0);
                tick();
            end
            data_data_ok = 1'b0;
            data_rdata   = $urandom;
            if (k == 1) expRdata = loadModel(s, ad[1:0], rd);
            for (int i = 0; i <= wDly; i++) begin
                W_allowin = (i == wDly);
                @(negedge clk);
                check("done_valid", 32'(M_to_W_valid), 32'd1);
                check("done_allowin", 32'(M_allowin), 32'(i == wDly));
                check("done_noreq", 32'(data_req), 32'd0);
                if (k == 1) check("load_data", mem_rdataM, expRdata);
                tick();
            end
        end
        M_valid   = 1'b0;
        MemWriteM = 1'b0;
        MemOrALUM = 1'b0;
        EXLM      = 1'b0;
        W_allowin = 1'b0;
    endtask

    task automatic startLoad(input logic [31:0] ad);
        M_valid    = 1'b1;
        MemOrALUM  = 1'b1;
        MemWriteM  = 1'b0;
        MemOutSelM = 3'd0;
        ALUoutM    = ad;
        W_allowin  = 1'b0;
        @(negedge clk);
        tick();
    endtask

    initial begin
        reset = 1'b0; respon = 1'b0; M_valid = 1'b0; W_allowin = 1'b0;
        MemWriteM = 1'b0; MemOrALUM = 1'b0; MemInSelM = 2'd0; MemOutSelM = 3'd0;
        ALUoutM = 32'h0; rd2M = 32'h0; EXLM = 1'b0; ExcCodeM = 5'd0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        expRdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", 32'(data_req), 32'd0);
        check("rst_valid", 32'(M_to_W_valid), 32'd0);
        check("rst_rdata", mem_rdataM, 32'd0);
        check("rst_exc", 32'(exc_validM), 32'd0);
        check("rst_allowin", 32'(M_allowin), 32'd1);
        reset = 1'b1;
        tick();

        runOp(2, 0, 32'h100, 32'h12345678, 32'h0, 0, 1, 2, 1'b0, 5'd0);
        runOp(1, 2, 32'h103, 32'h0, 32'h80FF0000, 1, 0, 0, 1'b0, 5'd0);
        runOp(1, 1, 32'h103, 32'h0, 32'h80FF0000, 0, 2, 1, 1'b0, 5'd0);
        runOp(2, 1, 32'h102, 32'h0000BEEF, 32'h0, 0, 0, 0, 1'b0, 5'd0);
        runOp(1, 0, 32'h102, 32'h0, 32'h0, 0, 0, 1, 1'b0, 5'd0);
        runOp(2, 0, 32'h101, 32'h0, 32'h0, 0, 0, 0, 1'b0, 5'd0);
        runOp(0, 0, 32'h55, 32'h0, 32'h0, 0, 0, 0, 1'b1, 5'h0C);
        runOp(0, 0, 32'h7, 32'h0, 32'h0, 0, 0, 2, 1'b0, 5'd0);

        // flush while waiting for data_ok; the late response is dropped
        startLoad(32'h200);
        data_addr_ok = 1'b1;
        @(negedge clk);
        check("fw_req", 32'(data_req), 32'd1);
        tick();
        data_addr_ok = 1'b0;
        respon = 1'b1;
        @(negedge clk);
        check("fw_flush_valid", 32'(M_to_W_valid), 32'd0);
        check("fw_flush_allowin", 32'(M_allowin), 32'd0);
        tick();
        respon = 1'b0; M_valid = 1'b0; MemOrALUM = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_data_ok = (i == 2);
            data_rdata   = 32'hDEADBEEF;
            @(negedge clk);
            check("fw_cancel_allowin", 32'(M_allowin), 32'd0);
            check("fw_cancel_noreq", 32'(data_req), 32'd0);
            tick();
        end
        data_data_ok = 1'b0;
        @(negedge clk);
        check("fw_idle_allowin", 32'(M_allowin), 32'd1);
        check("fw_idle_valid", 32'(M_to_W_valid), 32'd0);
        check("fw_discard", mem_rdataM, expRdata);
        tick();
        runOp(1, 0, 32'h204, 32'h0, 32'hCAFEF00D, 0, 0, 0, 1'b0, 5'd0);

        // flush before the address is accepted
        startLoad(32'h208);
        respon = 1'b1;
        @(negedge clk);
        check("fr_req", 32'(data_req), 32'd1);
        check("fr_valid", 32'(M_to_W_valid), 32'd0);
        tick();
        respon = 1'b0; M_valid = 1'b0; MemOrALUM = 1'b0;
        @(negedge clk);
        check("fr_noreq", 32'(data_req), 32'd0);
        check("fr_allowin", 32'(M_allowin), 32'd1);
        tick();
        runOp(1, 4, 32'h20A, 32'h0, 32'h8001_7FFF, 1, 1, 0, 1'b0, 5'd0);

        // async reset during WAIT
        startLoad(32'h300);
        data_addr_ok = 1'b1;
        @(negedge clk);
        tick();
        data_addr_ok = 1'b0;
        #2;
        reset = 1'b0; M_valid = 1'b0; MemOrALUM = 1'b0;
        #1;
        check("rw_req", 32'(data_req), 32'd0);
        check("rw_valid", 32'(M_to_W_valid), 32'd0);
        check("rw_rdata", mem_rdataM, 32'd0);
        check("rw_exc", 32'(exc_validM), 32'd0);
        expRdata = 32'h0;
        @(negedge clk);
        reset = 1'b1;
        tick();
        runOp(1, 0, 32'h304, 32'h0, 32'h13579BDF, 0, 0, 0, 1'b0, 5'd0);

        // async reset during REQ drops data_req at once
        startLoad(32'h308);
        #2;
        check("rr_pre", 32'(data_req), 32'd1);
        reset = 1'b0; M_valid = 1'b0; MemOrALUM = 1'b0;
        #1;
        check("rr_req", 32'(data_req), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 2));
            sel  = (kind == 1) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 2));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            runOp(kind, sel, addr, $urandom, $urandom,
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                  ($urandom_range(0, 7) == 0), 5'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m_mem_ctrl.md
Name: m_mem_ctrl

Overview:
- Memory-access controller for the M stage. Sits directly downstream of the E->M pipeline register.
- Consumes that register's M-side outputs and runs the data-bus request/response handshake for loads and stores.
- Generates byte strobes and load extension, and detects address-alignment exceptions.
- Drives M_allowin back to the E->M register and M_to_W_valid forward to the W stage.

Parameters:
- ADDR_W, 32, data-bus address width.
- EXC_ADEL, 5'd4, ExcCode for a misaligned load.
- EXC_ADES, 5'd5, ExcCode for a misaligned store.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- respon  in  1  pipeline flush on an exception/eret response.
- M_valid  in  1  M register holds a valid instruction.
- W_allowin  in  1  W stage can accept this cycle.
- MemWriteM  in  1  store.
- MemOrALUM  in  1  load (result comes from memory).
- MemInSelM  in  2  store size: 0 word, 1 half, 2 byte.
- MemOutSelM  in  3  load type: 0 lw, 1 lbu, 2 lb, 3 lhu, 4 lh.
- ALUoutM  in  32  effective address.
- rd2M  in  32  store data.
- EXLM  in  1  an exception is already flagged upstream.
- ExcCodeM  in  5  upstream exception code.
- M_allowin  out  1  E->M register may load.
- M_to_W_valid  out  1  M result valid toward W.
- data_req  out  1  bus request.
- data_wr  out  1  1 = store.
- data_size  out  2  0 byte, 1 half, 2 word.
- data_addr  out  32  request address.
- data_wstrb  out  4  byte-lane strobes.
- data_wdata  out  32  lane-replicated store data.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  response valid.
- data_rdata  in  32  load data.
- mem_rdataM  out  32  extended load result, held until W accepts.
- exc_validM  out  1  exception toward CP0.
- exc_codeM  out  5  exception code toward CP0.

Behaviour:
- Reset (async, reset=0):
  - state = IDLE.
  - data_req = 0, M_to_W_valid = 0, mem_rdataM = 0, exc_validM = 0.
- Definitions:
  - misalign = (word && addr[1:0] != 0) || (half && addr[0]).
  - exc_validM = M_valid && (EXLM || misalign).
  - exc_codeM = ExcCodeM if EXLM; otherwise EXC_ADEL for loads, EXC_ADES for stores.
  - mem_op = M_valid && (MemWriteM || MemOrALUM) && !exc_validM.
- States: IDLE, REQ, WAIT, DONE, CANCEL.
- IDLE:
  - If mem_op and !respon, go to REQ next cycle.
  - Otherwise M_to_W_valid = M_valid (covers non-memory ops and excepting ops; no bus activity).
- REQ:
  - data_req = 1, with data_addr/data_size/data_wstrb/data_wdata/data_wr held stable.
  - addr_ok && data_ok in the same cycle: go to DONE.
  - addr_ok alone: go to WAIT.
- WAIT: on data_ok, capture the extended data_rdata into mem_rdataM and go to DONE.
- DONE:
  - M_to_W_valid = 1.
  - On W_allowin, go to IDLE; the E->M register loads in that same cycle.
- M_allowin = !M_valid || (M_to_W_valid && W_allowin). Forced to 0 in REQ, WAIT and CANCEL.
- Store lanes (a = addr[1:0]):
  - byte: wstrb = 1<<a, wdata = {4{rd2[7:0]}}.
  - half: wstrb = a[1] ? 4'b1100 : 4'b0011, wdata = {2{rd2[15:0]}}.
  - word: wstrb = 4'hF, wdata = rd2.
  - Loads: wstrb = 0.
- Load extension: select the byte/half by a from data_rdata, then zero- or sign-extend per MemOutSelM.
- Flush (respon):
  - IDLE/REQ without addr_ok: go to IDLE, no transaction.
  - REQ with addr_ok (no data_ok), or WAIT: go to CANCEL.
  - REQ with addr_ok && data_ok: go to IDLE.
  - CANCEL: wait for data_ok, discard the data, go to IDLE.
  - DONE: go to IDLE.
  - M_to_W_valid = 0 in the flush cycle.
- Latency:
  - Non-memory op: 0 extra cycles.
  - Memory op: at least 2 cycles (REQ, DONE) when addr_ok and data_ok arrive together.
- Only one outstanding bus transaction at any time; no new req is issued while in WAIT or CANCEL.

Decomposition:
- Shared package holds:
  - state encoding;
  - MemInSel / MemOutSel / data_size encodings;
  - EXC_ADEL and EXC_ADES.
- One natural sub-module: m_load_ext (pure combinational byte/half select and extend), instanced once.

Test Plan:
- sw 0x12345678 to 0x100, addr_ok in cycle 1, data_ok in cycle 2 -> wstrb = F, wdata = 0x12345678; M_to_W_valid rises in DONE; M_allowin = 0 until W_allowin.
- lb at 0x103, rdata = 0x80FF0000 -> mem_rdataM = 0xFFFFFF80. lbu at the same address -> 0x00000080.
- sh 0xBEEF to 0x102 -> wstrb = 4'b1100, wdata = 0xBEEFBEEF.
- lw at 0x102 -> no data_req; exc_validM = 1, exc_codeM = 4; M_to_W_valid = 1 in the same cycle.
- respon asserted in WAIT -> CANCEL holds M_allowin = 0; data_ok 3 cycles later is discarded; IDLE follows, and the next lw issues a fresh req.
- reset pulled low while in WAIT -> state = IDLE and data_req = 0 immediately (async); M_to_W_valid = 0.
